// File: rtl/mem_arbiter_pkg.sv
// Shared types, default widths and the round-robin pick helper for the
// I-cache / D-cache memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 16;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Requester identity, also used to remember who was served last
  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  // Choose the side to grant; only meaningful when at least one side is pending.
  // On a tie the side that was not served last wins.
  function automatic side_t pick_side(input logic i_pend, input logic d_pend,
                                      input side_t last);
    if (i_pend && d_pend) begin
      return (last == SIDE_I) ? SIDE_D : SIDE_I;
    end else if (i_pend) begin
      return SIDE_I;
    end else begin
      return SIDE_D;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the arbiter.
// The slave modport is the arbiter's view, master is the environment's view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  // Memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Statistics
  logic [CNT_W-1:0]  i_txn_cnt;
  logic [CNT_W-1:0]  d_txn_cnt;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
           mem_wdata, i_txn_cnt, d_txn_cnt
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
           mem_wdata, i_txn_cnt, d_txn_cnt
  );

endinterface

// File: rtl/mem_arbiter_sat_cnt.sv
// Saturating up-counter: counts completed transactions, sticks at all-ones.
module arb_sat_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  // Count up on each increment request, holding once the maximum is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-cache and the D-cache, one
// transaction at a time, with round-robin resolution of simultaneous requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_t        r_state;
  side_t             r_last;

  logic              w_i_pend;
  logic              w_d_pend;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_i_ready;
  logic              w_d_ready;
  logic [DATA_W-1:0] w_i_rdata;
  logic [DATA_W-1:0] w_d_rdata;
  logic [1:0]        w_done;
  logic [CNT_W-1:0]  w_cnt [2];

  assign w_i_pend = bus.i_read;
  assign w_d_pend = bus.d_read | bus.d_write;

  // Grant FSM: arbitrate in IDLE, hold the grant until memory completes.
  // A dropped request does not release the grant; only mem_ready does.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= SIDE_I;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_pend || w_d_pend) begin
            r_state <= (pick_side(w_i_pend, w_d_pend, r_last) == SIDE_I) ? GNT_I : GNT_D;
          end
        end
        GNT_I: begin
          if (bus.mem_ready) begin
            r_state <= IDLE;
            r_last  <= SIDE_I;
          end
        end
        GNT_D: begin
          if (bus.mem_ready) begin
            r_state <= IDLE;
            r_last  <= SIDE_D;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Route the granted requester onto the memory port; ready/rdata pass straight through
  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_i_ready   = 1'b0;
    w_d_ready   = 1'b0;
    w_i_rdata   = '0;
    w_d_rdata   = '0;
    case (r_state)
      GNT_I: begin
        w_mem_read = bus.i_read;
        w_mem_addr = bus.i_addr;
        w_i_ready  = bus.mem_ready;
        w_i_rdata  = bus.mem_rdata;
      end
      GNT_D: begin
        // A write-back takes priority if the D-cache raises both strobes
        w_mem_write = bus.d_write;
        w_mem_read  = bus.d_read & ~bus.d_write;
        w_mem_addr  = bus.d_addr;
        w_mem_wdata = bus.d_wdata;
        w_d_ready   = bus.mem_ready;
        w_d_rdata   = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  // Index 0 counts I-side completions, index 1 counts D-side completions
  assign w_done = {w_d_ready, w_i_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      arb_sat_cnt #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_inc(w_done[gi]),
        .o_cnt(w_cnt[gi])
      );
    end
  endgenerate

  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.i_ready   = w_i_ready;
  assign bus.d_ready   = w_d_ready;
  assign bus.i_rdata   = w_i_rdata;
  assign bus.d_rdata   = w_d_rdata;
  assign bus.i_txn_cnt = w_cnt[0];
  assign bus.d_txn_cnt = w_cnt[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2))  bus_s ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // Narrow-counter instance used to reach saturation in a handful of transactions
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who currently owns the port (0 none, 1 I, 2 D),
  // who was served last (1 I, 2 D) and completed-transaction tallies.
  int m_owner, m_prev, m_icnt, m_dcnt;

  // Observations captured at the falling edge of the last cycle
  logic          o_mr, o_mw, o_ir, o_dr;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_irdata, o_drdata;
  logic          last_ir, last_dr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    n_checks++;
    if (obs !== want) $display("FAIL %s: got %0h, want %0h", tag, obs, want);
    else n_pass++;
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, then advance the model
  task automatic cycle();
    logic          e_mr, e_mw, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    e_mr   = (m_owner == 1 && bus.i_read) || (m_owner == 2 && bus.d_read && !bus.d_write);
    e_mw   = (m_owner == 2) && bus.d_write;
    e_addr = (m_owner == 1) ? bus.i_addr : (m_owner == 2) ? bus.d_addr : '0;
    e_wd   = (m_owner == 2) ? bus.d_wdata : '0;
    e_ir   = (m_owner == 1) && bus.mem_ready;
    e_dr   = (m_owner == 2) && bus.mem_ready;
    chk("mem_read",  DW'(bus.mem_read),  DW'(e_mr));
    chk("mem_write", DW'(bus.mem_write), DW'(e_mw));
    chk("mem_addr",  DW'(bus.mem_addr),  DW'(e_addr));
    chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("i_ready",   DW'(bus.i_ready),   DW'(e_ir));
    chk("d_ready",   DW'(bus.d_ready),   DW'(e_dr));
    if (e_ir) chk("i_rdata", bus.i_rdata, bus.mem_rdata);
    if (e_dr) chk("d_rdata", bus.d_rdata, bus.mem_rdata);
    chk("i_txn_cnt", DW'(bus.i_txn_cnt), DW'(m_icnt));
    chk("d_txn_cnt", DW'(bus.d_txn_cnt), DW'(m_dcnt));
    o_mr = bus.mem_read;  o_mw = bus.mem_write; o_ir = bus.i_ready; o_dr = bus.d_ready;
    o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
    o_irdata = bus.i_rdata; o_drdata = bus.d_rdata;
    last_ir = e_ir; last_dr = e_dr;
    @(posedge clk);
    if (rst) begin
      m_owner = 0; m_prev = 1; m_icnt = 0; m_dcnt = 0;
    end else if (m_owner == 0) begin
      if (bus.i_read && (bus.d_read || bus.d_write)) m_owner = 3 - m_prev;
      else if (bus.i_read) m_owner = 1;
      else if (bus.d_read || bus.d_write) m_owner = 2;
    end else if (bus.mem_ready) begin
      if (m_owner == 1) m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
      else              m_dcnt = (m_dcnt < CMAX) ? m_dcnt + 1 : CMAX;
      m_prev  = m_owner;
      m_owner = 0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    bus_s.i_read = 1'b0; bus_s.i_addr = '0;
    bus_s.d_read = 1'b0; bus_s.d_write = 1'b0; bus_s.d_addr = '0; bus_s.d_wdata = '0;
    bus_s.mem_rdata = '0; bus_s.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] k1, w1;
    logic          want_d [4];
    int            kind;
    m_owner = 0; m_prev = 1; m_icnt = 0; m_dcnt = 0;
    clear_inputs();
    do_reset();

    // Reset state: nothing on the memory port, counters cleared
    cycle();
    chk("rst_mem_read",  DW'(o_mr),   DW'(0));
    chk("rst_mem_write", DW'(o_mw),   DW'(0));
    chk("rst_mem_addr",  DW'(o_addr), DW'(0));
    chk("rst_i_cnt",     DW'(bus.i_txn_cnt), DW'(0));
    chk("rst_d_cnt",     DW'(bus.d_txn_cnt), DW'(0));

    // Single I read at 0x10, memory answers in the third granted cycle
    k1 = {$urandom, $urandom, $urandom, $urandom};
    bus.i_read = 1'b1; bus.i_addr = AW'(28'h0000010);
    cycle(); chk("ird_c1_idle", DW'(o_mr), DW'(0));
    cycle(); chk("ird_c2_read", DW'(o_mr), DW'(1)); chk("ird_c2_addr", DW'(o_addr), DW'(28'h10));
    cycle(); chk("ird_c3_read", DW'(o_mr), DW'(1)); chk("ird_c3_rdy", DW'(o_ir), DW'(0));
    bus.mem_ready = 1'b1; bus.mem_rdata = k1;
    cycle(); chk("ird_c4_read", DW'(o_mr), DW'(1)); chk("ird_c4_rdy", DW'(o_ir), DW'(1));
    chk("ird_c4_rdata", o_irdata, k1);
    bus.mem_ready = 1'b0; bus.i_read = 1'b0;
    cycle(); chk("ird_cnt", DW'(bus.i_txn_cnt), DW'(1)); chk("ird_after", DW'(o_mr), DW'(0));

    // Both sides hold requests continuously from reset: grants alternate D, I, D, I
    do_reset();
    want_d = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.i_read = 1'b1; bus.i_addr = AW'(28'h100);
    bus.d_read = 1'b1; bus.d_addr = AW'(28'h200);
    for (int g = 0; g < 4; g++) begin
      bus.mem_ready = 1'b0;
      cycle();
      bus.mem_ready = 1'b1;
      cycle();
      chk("rr_d_ready", DW'(o_dr), DW'(want_d[g]));
      chk("rr_i_ready", DW'(o_ir), DW'(!want_d[g]));
    end
    clear_inputs();
    cycle();

    // D read and write together: the write wins
    do_reset();
    w1 = {$urandom, $urandom, $urandom, $urandom};
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = AW'(28'h00000A0); bus.d_wdata = w1;
    cycle();
    cycle();
    chk("rw_mem_write", DW'(o_mw), DW'(1));
    chk("rw_mem_read",  DW'(o_mr), DW'(0));
    chk("rw_mem_addr",  DW'(o_addr), DW'(28'hA0));
    chk("rw_mem_wdata", o_wdata, w1);
    bus.mem_ready = 1'b1;
    cycle(); chk("rw_d_ready", DW'(o_dr), DW'(1));
    clear_inputs();
    cycle(); chk("rw_d_cnt", DW'(bus.d_txn_cnt), DW'(1));

    // Reset in the middle of a D grant, then a late mem_ready
    do_reset();
    bus.d_read = 1'b1; bus.d_addr = AW'(28'h300);
    cycle();
    cycle(); chk("mrst_granted", DW'(o_mr), DW'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0; bus.d_read = 1'b0;
    cycle(); chk("mrst_read_low", DW'(o_mr), DW'(0)); chk("mrst_write_low", DW'(o_mw), DW'(0));
    bus.mem_ready = 1'b1;
    cycle(); chk("mrst_no_ready", DW'(o_dr), DW'(0));
    bus.mem_ready = 1'b0;
    cycle(); chk("mrst_d_cnt", DW'(bus.d_txn_cnt), DW'(0));

    // I request withdrawn before memory completes: grant held with strobe low
    bus.i_read = 1'b1; bus.i_addr = AW'(28'h400);
    cycle();
    cycle(); chk("drop_granted", DW'(o_mr), DW'(1));
    bus.i_read = 1'b0;
    cycle(); chk("drop_strobe_low", DW'(o_mr), DW'(0));
    bus.mem_ready = 1'b1;
    cycle(); chk("drop_ready", DW'(o_ir), DW'(1));
    bus.mem_ready = 1'b0;
    cycle(); chk("drop_i_cnt", DW'(bus.i_txn_cnt), DW'(1));

    // Saturation on the 2-bit counter instance: 1, 2, 3, 3, 3
    clear_inputs();
    do_reset();
    bus_s.d_read = 1'b1; bus_s.d_addr = AW'(28'h500);
    for (int k = 1; k <= 5; k++) begin
      bus_s.mem_ready = 1'b0;
      cycle();
      bus_s.mem_ready = 1'b1;
      cycle();
      chk("sat_d_cnt", DW'(bus_s.d_txn_cnt), DW'((k < 3) ? k : 3));
    end
    clear_inputs();
    cycle();

    // Randomized traffic with occasional resets and stray mem_ready pulses
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 250 == 0);
      cycle();
      if (last_ir) begin
        bus.i_read = 1'b0;
      end else if (!bus.i_read && ($urandom % 3 == 0)) begin
        bus.i_read = 1'b1; bus.i_addr = AW'($urandom);
      end
      if (last_dr) begin
        bus.d_read = 1'b0; bus.d_write = 1'b0;
      end else if (!(bus.d_read || bus.d_write) && ($urandom % 3 == 0)) begin
        kind = int'($urandom % 3);
        bus.d_read  = (kind != 1);
        bus.d_write = (kind != 0);
        bus.d_addr  = AW'($urandom);
        bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_ready = (m_owner != 0) ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 28, memory block address width
  DATA_W, 128, memory block data width
  CNT_W, 16, transaction counter width
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  reset, synchronous and active-high
  i_read  in  1  I-cache block read request
  i_addr  in  ADDR_W  I-cache block address
  i_rdata  out  DATA_W  read data to I-cache
  i_ready  out  1  I-cache transaction complete
  d_read  in  1  D-cache block read request
  d_write  in  1  D-cache block write-back request
  d_addr  in  ADDR_W  D-cache block address
  d_wdata  in  DATA_W  D-cache write data
  d_rdata  out  DATA_W  read data to D-cache
  d_ready  out  1  D-cache transaction complete
  mem_read  out  1  memory read strobe
  mem_write  out  1  memory write strobe
  mem_addr  out  ADDR_W  memory block address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in  DATA_W  memory read data
  mem_ready  in  1  memory transaction complete, one-cycle pulse
  i_txn_cnt  out  CNT_W  completed I-side transactions
  d_txn_cnt  out  CNT_W  completed D-side transactions

Function
REQ-003 Block SHALL share the single memory port between I-cache and D-cache, one transaction in flight at a time.
REQ-004 FSM states SHALL be IDLE, GNT_I, GNT_D.
REQ-005 In IDLE: mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_ready=d_ready=0.
REQ-006 IDLE transitions: only I pending -> GNT_I; only D pending (d_read|d_write) -> GNT_D; both -> side not granted last (round-robin); none -> IDLE.
REQ-007 Arbitration latency SHALL be one cycle: request seen in IDLE, strobe asserted in the following cycle.
REQ-008 In GNT_I: mem_read=i_read, mem_write=0, mem_addr=i_addr; i_ready=mem_ready; i_rdata=mem_rdata.
REQ-009 In GNT_D: mem_write=d_write, mem_read=d_read & ~d_write (write wins if both asserted), mem_addr=d_addr, mem_wdata=d_wdata; d_ready=mem_ready; d_rdata=mem_rdata.
REQ-010 Ready and rdata paths SHALL be combinational pass-through in the cycle mem_ready is high; the non-granted side's ready SHALL be 0.
REQ-011 On mem_ready in GNT_x: next state IDLE; last-grant bit set to x; corresponding counter increments.
REQ-012 Requesters hold request and address stable until their ready and drop the request the cycle after; a new request that is still high in IDLE is arbitrated normally.
REQ-013 If the granted request drops before mem_ready (protocol violation), FSM SHALL remain in GNT_x with strobes low until mem_ready, then return to IDLE.
REQ-014 Counters SHALL saturate at 2^CNT_W-1, no wrap.
REQ-015 A requester pending in IDLE SHALL be granted within two transactions (no starvation).

Reset
REQ-016 rst high at a clock edge SHALL force IDLE, last-grant=I (D wins the first tie), both counters 0; outputs read REQ-005 values the next cycle, including mid-transaction.
REQ-017 mem_ready arriving after a mid-transaction reset SHALL be ignored: no ready, no count.

Structure
REQ-018 State encoding, ADDR_W/DATA_W/CNT_W defaults SHALL reside in the shared package.
REQ-019 The saturating counter SHALL be one sub-module, arb_sat_cnt, instantiated twice.

Verification
REQ-020 Idle I read 0x0000010, mem_ready after 3 cycles -> mem_read high cycles 2-4, i_ready pulse in cycle 4 with i_rdata=mem_rdata, i_txn_cnt=1.
REQ-021 I and D both request from reset -> GNT_D first, GNT_I second; reversed order on the next simultaneous pair.
REQ-022 D read and write both asserted, d_addr=0x00000A0 -> mem_write=1, mem_read=0, mem_wdata=d_wdata.
REQ-023 rst during GNT_D before mem_ready -> next cycle all strobes 0, late mem_ready produces no d_ready, d_txn_cnt=0.
REQ-024 Preload d_txn_cnt to 0xFFFE, complete 3 D transactions -> counter holds 0xFFFF.
REQ-025 D requests continuously while I pending -> I granted no later than the second grant.
